hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use interlock, multi-cycle MUL/SDIV stall,
// taken-branch IF flush, and a saturating counter of PC-stalled cycles.
`timescale 1ns/1ps

module hazard_unit #(
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rn_DEC,
  input  logic [4:0]  Rm_DEC,
  input  logic [4:0]  Rd_DEC,
  input  logic        UsesRm_DEC,
  input  logic        ReadsRd_DEC,
  input  logic        BrTaken_DEC,
  input  logic [4:0]  Rd_EX,
  input  logic        MemRead_EX,
  input  logic        RegWrite_EX,
  input  logic        MulDiv_EX,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        Bubble_EX,
  output logic        Bubble_MEM,
  output logic        Flush_IF,
  output logic        Busy,
  output logic [15:0] StallCnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } state_e;

  // The first stall cycle happens in IDLE, so DIV_WAIT covers the remaining DIV_LAT-2.
  localparam logic [3:0] CNT_INIT = 4'(DIV_LAT - 2);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic div_stall;
  logic eval_lu_br;

  // X31 is the zero register: a load targeting it never creates a dependency.
  assign lu = MemRead_EX && RegWrite_EX && (Rd_EX != 5'd31) &&
              ((Rn_DEC == Rd_EX) ||
               (UsesRm_DEC  && (Rm_DEC == Rd_EX)) ||
               (ReadsRd_DEC && (Rd_DEC == Rd_EX)));

  assign div_stall  = ((state_q == IDLE) && MulDiv_EX) || (state_q == DIV_WAIT);
  assign eval_lu_br = (state_q == IDLE) || (state_q == DIV_DONE);

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    Bubble_EX  = 1'b0;
    Bubble_MEM = 1'b0;
    Flush_IF   = 1'b0;
    Busy       = 1'b0;
    if (!reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXWrite = 1'b0;
    end else if (div_stall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      Bubble_MEM = 1'b1;
      Busy       = 1'b1;
    end else if (eval_lu_br && lu) begin
      // A branch coincident with LU is held off and re-evaluated next cycle.
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Bubble_EX = 1'b1;
    end else if (eval_lu_br && BrTaken_DEC) begin
      Flush_IF = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MulDiv_EX) begin
          cnt_d   = CNT_INIT;
          state_d = (DIV_LAT == 2) ? DIV_DONE : DIV_WAIT;
        end
      end
      DIV_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign stall_cnt_d = (!PCWrite && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                : stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;

endmodule
